// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: datapath width and operation codes.
// alu_op_e values match the ALUControl field produced by the decoder.
package alu_pkg;

  localparam int XLEN = 64;

  typedef enum logic [3:0] {
    ALU_AND   = 4'b0000,
    ALU_OR    = 4'b0001,
    ALU_ADD   = 4'b0010,
    ALU_SLL   = 4'b0011,
    ALU_SLTU  = 4'b0100,
    ALU_SGEU  = 4'b0101,
    ALU_SUB   = 4'b0110,
    ALU_SRL   = 4'b0111,
    ALU_XOR   = 4'b1000,
    ALU_PASSB = 4'b1010,
    ALU_SRA   = 4'b1011,
    ALU_SLT   = 4'b1100,
    ALU_SGE   = 4'b1101
  } alu_op_e;

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU core: result and zero flag from operands and operation code.
// Unassigned codes produce zero so the output is never left undriven.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  output logic [WIDTH-1:0] res_o,
  output logic             res_zero_o
);

  logic [SHW-1:0] shamt;
  logic           lt_u;
  logic           lt_s;

  // Only the low bits of b select the shift distance.
  assign shamt = b_i[SHW-1:0];

  // Native signed compare, not derived from the sign of a-b, so it cannot overflow.
  assign lt_u = (a_i < b_i);
  assign lt_s = ($signed(a_i) < $signed(b_i));

  always_comb begin
    res_o = '0;
    case (op_i)
      ALU_AND:   res_o = a_i & b_i;
      ALU_OR:    res_o = a_i | b_i;
      ALU_XOR:   res_o = a_i ^ b_i;
      ALU_ADD:   res_o = a_i + b_i;
      ALU_SUB:   res_o = a_i - b_i;
      ALU_PASSB: res_o = b_i;
      ALU_SLL:   res_o = a_i << shamt;
      ALU_SRL:   res_o = a_i >> shamt;
      ALU_SRA:   res_o = $signed(a_i) >>> shamt;
      ALU_SLTU:  res_o = {{(WIDTH-1){1'b0}}, lt_u};
      ALU_SGEU:  res_o = {{(WIDTH-1){1'b0}}, ~lt_u};
      ALU_SLT:   res_o = {{(WIDTH-1){1'b0}}, lt_s};
      ALU_SGE:   res_o = {{(WIDTH-1){1'b0}}, ~lt_s};
      default:   res_o = '0;
    endcase
  end

  assign res_zero_o = (res_o == '0);

endmodule

// File: rtl/alu_unit.sv
// Execute-stage ALU with a one-cycle registered result, zero flag and valid strobe.
// Result and zero only update on accepted operations; reset forces result 0 / zero 1.
module alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ALUControl,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             valid_out
);

  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] result_q;
  logic             zero_d;
  logic             zero_q;
  logic             valid_q;

  alu_comb #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_alu_comb (
    .a_i        (a),
    .b_i        (b),
    .op_i       (ALUControl),
    .res_o      (result_d),
    .res_zero_o (zero_d)
  );

  // Reset takes priority over valid_in, dropping any operation presented that edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= valid_in;
      if (valid_in) begin
        result_q <= result_d;
        zero_q   <= zero_d;
      end
    end
  end

  assign result    = result_q;
  assign zero      = zero_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vectors plus randomized traffic
// checked against an arithmetic reference model of the ALU.
module tb_alu_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [63:0] a;
  logic [63:0] b;
  logic [3:0]  ALUControl;
  logic [63:0] result;
  logic        zero;
  logic        valid_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [63:0] m_result = '0;
  logic        m_zero   = 1'b1;
  logic        m_valid  = 1'b0;

  typedef struct packed {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } vec_t;

  always #5 clk = ~clk;

  alu_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .a          (a),
    .b          (b),
    .ALUControl (ALUControl),
    .result     (result),
    .zero       (zero),
    .valid_out  (valid_out)
  );

  // Reference: shifts as multiply/divide by powers of two, signed order from sign bits.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [63:0] x,
                                       input logic [63:0] y);
    logic [63:0] p2;
    logic        ltu;
    logic        lts;
    int          sh;
    sh  = int'(y % 64);
    p2  = 64'd1;
    for (int i = 0; i < sh; i++) p2 = p2 * 64'd2;
    ltu = (x < y);
    lts = (x[63] != y[63]) ? x[63] : ltu;
    case (op)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b1000: return x ^ y;
      4'b0010: return x + y;
      4'b0110: return x - y;
      4'b1010: return y;
      4'b0011: return x * p2;
      4'b0111: return x / p2;
      4'b1011: return x[63] ? ~((~x) / p2) : (x / p2);
      4'b0100: return {63'd0, ltu};
      4'b0101: return {63'd0, !ltu};
      4'b1100: return {63'd0, lts};
      4'b1101: return {63'd0, !lts};
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      4:       return 64'($urandom_range(0, 70));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // One clock edge; the model tracks what the registers should hold afterwards.
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      m_result = '0;
      m_zero   = 1'b1;
      m_valid  = 1'b0;
    end else begin
      m_valid = valid_in;
      if (valid_in) begin
        m_result = model(ALUControl, a, b);
        m_zero   = (m_result == 64'd0);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid_in = 1'b1; ALUControl = 4'b0001; a = '1; b = '1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (result !== 64'd0 || zero !== 1'b1 || valid_out !== 1'b0) begin
        n_bad++;
        $display("FAIL reset[%0d]: got result=%h zero=%b valid=%b, want 0/1/0",
                 i, result, zero, valid_out);
      end
    end
  endtask

  task automatic test_vectors(input string name, input vec_t v[$]);
    rst_n = 1'b1;
    foreach (v[i]) begin
      valid_in = 1'b1; ALUControl = v[i].op; a = v[i].a; b = v[i].b;
      step();
      n_cmp++;
      if (result !== v[i].exp) begin
        n_bad++;
        $display("FAIL %s[%0d] op=%b result: got %h want %h", name, i, v[i].op, result, v[i].exp);
      end
      n_cmp++;
      if (zero !== (v[i].exp == 64'd0) || valid_out !== 1'b1) begin
        n_bad++;
        $display("FAIL %s[%0d] op=%b zero/valid: got %b/%b want %b/1", name, i, v[i].op,
                 zero, valid_out, (v[i].exp == 64'd0));
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic test_logic_arith();
    vec_t v[$];
    v.push_back('{4'b0000, '1, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE});
    v.push_back('{4'b0001, '1, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF});
    v.push_back('{4'b0010, '1, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD});
    v.push_back('{4'b0110, '1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1});
    v.push_back('{4'b0100, '1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0});
    v.push_back('{4'b0101, '1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1});
    v.push_back('{4'b1100, '1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0});
    v.push_back('{4'b1101, '1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1});
    v.push_back('{4'b1000, 64'hF0F0, 64'h0FF0, 64'hFF00});
    v.push_back('{4'b1010, 64'h1234, 64'hABCD_0000_0000, 64'hABCD_0000_0000});
    test_vectors("logic_arith", v);
  endtask

  task automatic test_shift_compare();
    vec_t v[$];
    v.push_back('{4'b0100, '1, 64'd2, 64'd0});
    v.push_back('{4'b0101, '1, 64'd2, 64'd1});
    v.push_back('{4'b1100, '1, 64'd2, 64'd1});
    v.push_back('{4'b1101, '1, 64'd2, 64'd0});
    v.push_back('{4'b0011, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFC});
    v.push_back('{4'b0111, '1, 64'd2, 64'h3FFF_FFFF_FFFF_FFFF});
    v.push_back('{4'b1011, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF});
    v.push_back('{4'b1111, '1, 64'd2, 64'd0});
    v.push_back('{4'b0100, 64'd1, 64'd2, 64'd1});
    v.push_back('{4'b0101, 64'd1, 64'd2, 64'd0});
    v.push_back('{4'b1100, 64'd1, 64'd2, 64'd1});
    v.push_back('{4'b1101, 64'd1, 64'd2, 64'd0});
    v.push_back('{4'b0011, 64'd1, 64'd2, 64'd4});
    v.push_back('{4'b0111, 64'd1, 64'd2, 64'd0});
    v.push_back('{4'b1011, 64'd1, 64'd2, 64'd0});
    test_vectors("shift_cmp", v);
  endtask

  task automatic test_edges();
    vec_t v[$];
    v.push_back('{4'b0000, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0});
    v.push_back('{4'b0010, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF});
    v.push_back('{4'b1100, 64'h8000_0000_0000_0000, 64'd1, 64'd1});
    v.push_back('{4'b0100, 64'h8000_0000_0000_0000, 64'd1, 64'd0});
    v.push_back('{4'b0011, 64'd3, 64'h41, 64'd6});
    v.push_back('{4'b0010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000});
    v.push_back('{4'b1011, 64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF});
    v.push_back('{4'b0111, 64'h8000_0000_0000_0000, 64'hFFC0, 64'h8000_0000_0000_0000});
    v.push_back('{4'b1001, 64'd5, 64'd7, 64'd0});
    v.push_back('{4'b1110, 64'd5, 64'd7, 64'd0});
    test_vectors("edges", v);
  endtask

  task automatic test_hold();
    rst_n = 1'b0; valid_in = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ALUControl = 4'($urandom); a = rnd64(); b = rnd64();
      step();
      n_cmp++;
      if (result !== 64'd0 || zero !== 1'b1 || valid_out !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_after_reset[%0d]: got %h/%b/%b want 0/1/0", i, result, zero, valid_out);
      end
    end
    valid_in = 1'b1; ALUControl = 4'b0010; a = 64'd5; b = 64'd6;
    step();
    valid_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ALUControl = 4'b0000; a = rnd64(); b = 64'd0;
      step();
      n_cmp++;
      if (result !== 64'd11 || zero !== 1'b0 || valid_out !== 1'b0) begin
        n_bad++;
        $display("FAIL hold_value[%0d]: got %h/%b/%b want b/0/0", i, result, zero, valid_out);
      end
    end
  endtask

  task automatic test_reset_midstream();
    rst_n = 1'b1; valid_in = 1'b1; ALUControl = 4'b0001; a = 64'h55; b = 64'hAA00;
    step();
    rst_n = 1'b0; ALUControl = 4'b0010; a = 64'd1; b = 64'd1;
    step();
    n_cmp++;
    if (result !== 64'd0 || zero !== 1'b1 || valid_out !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_midstream: got %h/%b/%b want 0/1/0", result, zero, valid_out);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (result !== 64'd2 || zero !== 1'b0 || valid_out !== 1'b1) begin
      n_bad++;
      $display("FAIL first_after_reset: got %h/%b/%b want 2/0/1", result, zero, valid_out);
    end
  endtask

  task automatic test_back_to_back();
    rst_n = 1'b1; valid_in = 1'b1;
    for (int i = 0; i < 40; i++) begin
      ALUControl = 4'($urandom); a = rnd64(); b = rnd64();
      step();
      n_cmp++;
      if (result !== m_result || zero !== m_zero || valid_out !== 1'b1) begin
        n_bad++;
        $display("FAIL back_to_back[%0d]: got %h/%b/%b want %h/%b/1", i, result, zero,
                 valid_out, m_result, m_zero);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst_n      = ($urandom_range(0, 39) != 0);
      valid_in   = ($urandom_range(0, 3) != 0);
      ALUControl = 4'($urandom);
      a          = rnd64();
      b          = rnd64();
      step();
      n_cmp++;
      if (result !== m_result || zero !== m_zero || valid_out !== m_valid) begin
        n_bad++;
        $display("FAIL random[%0d]: got %h/%b/%b want %h/%b/%b", i, result, zero, valid_out,
                 m_result, m_zero, m_valid);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; ALUControl = 4'b0000; a = '0; b = '0;
    test_reset();
    test_logic_arith();
    test_shift_compare();
    test_edges();
    test_hold();
    test_reset_midstream();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
